// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and the fetch-entry record used by the
//                instruction-fetch stage and its skid FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    // Default widths of the fetch datapath (byte-address PC, 32-bit instr)
    localparam int FETCH_PC_W  = 9;
    localparam int FETCH_INS_W = 32;

    // PC loaded on reset
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Instruction presented to decode when nothing valid is available
    // (addi x0, x0, 0)
    localparam logic [FETCH_INS_W-1:0] NOP_INSTR = 32'h0000_0013;

    // Sequential PC step in bytes
    localparam int PC_INC = 4;

    // Number of entries held between memory response and decode
    localparam int FIFO_DEPTH = 2;

    // One fetched instruction together with the address it came from
    typedef struct packed {
        logic [FETCH_PC_W-1:0]  pc;
        logic [FETCH_INS_W-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_fifo
//  Description : Two-entry skid FIFO of fetch entries. Head is always at
//                slot 0; push and pop may happen together at any fill level;
//                flush empties the FIFO and wins over push/pop.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,          // synchronous, active-low
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_push_entry,
    input  logic         i_pop,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_mem [FIFO_DEPTH];
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_empty;

    // A pop on an empty FIFO is meaningless and is ignored
    assign w_empty = (r_count == 2'd0);
    assign w_pop   = i_pop && !w_empty;

    // Occupancy counter; flush clears it regardless of push/pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage shifts toward slot 0 on pop; the new entry lands right behind
    // whatever survives the pop
    always_ff @(posedge clk) begin
        if (!i_flush) begin
            if (w_pop) begin
                if (i_push && (r_count == 2'd1)) begin
                    r_mem[0] <= i_push_entry;
                end else begin
                    r_mem[0] <= r_mem[1];
                    if (i_push) begin
                        r_mem[1] <= i_push_entry;
                    end
                end
            end else if (i_push) begin
                if (w_empty) begin
                    r_mem[0] <= i_push_entry;
                end else begin
                    r_mem[1] <= i_push_entry;
                end
            end
        end
    end

    // Head of queue, or a harmless NOP at PC 0 when empty
    always_comb begin
        o_head.pc    = '0;
        o_head.instr = NOP_INSTR;
        if (!w_empty) begin
            o_head = r_mem[0];
        end
    end

    assign o_count = r_count;

    // Upstream credit accounting must never push into a full FIFO unless
    // the head is leaving in the same cycle
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(i_push && !i_flush && !w_pop && (r_count == 2'd2)));

endmodule : fetch_skid_fifo
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_unit
//  Description : Instruction-fetch stage. Owns the architectural PC, drives
//                the synchronous instruction memory, and hands (pc, instr)
//                pairs to decode over valid/ready. One request may be in
//                flight; responses land in a 2-entry skid FIFO so stalls and
//                redirects never lose or duplicate instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int PC_W  = FETCH_PC_W,
    parameter int INS_W = FETCH_INS_W
) (
    input  logic             clk,
    input  logic             reset,      // synchronous, active-low
    input  logic             stall,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    output logic             imem_en,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    output logic             if_valid,
    input  logic             id_ready,
    output logic [PC_W-1:0]  if_pc,
    output logic [INS_W-1:0] if_instr
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_req_pc;
    logic            r_req_v;

    logic [1:0]      w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [2:0]      w_occ;
    logic [2:0]      w_occ_after_pop;
    logic [PC_W-1:0] w_redirect_pc;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_unused_br;

    // Handshake and credit: every issued request must have a guaranteed
    // FIFO slot by the time its data returns, counting the head that
    // decode is accepting this cycle
    assign w_pop           = if_valid & id_ready;
    assign w_occ           = {1'b0, w_count} + {2'b00, r_req_v};
    assign w_occ_after_pop = w_occ - {2'b00, w_pop};
    assign w_issue         = reset & ~PcSel & ~stall & (w_occ_after_pop < 3'd2);

    assign imem_en   = w_issue;
    assign imem_addr = r_pc;

    // Redirect target is word aligned and truncated to the PC width
    assign w_redirect_pc = {BrPC[PC_W-1:2], 2'b00};
    assign w_pc_inc      = PC_W'(PC_INC);
    assign w_unused_br   = ^{BrPC[31:PC_W], BrPC[1:0]};

    // Memory response joins the FIFO tail unless a redirect squashes it
    assign w_push             = r_req_v & ~PcSel;
    assign w_push_entry.pc    = r_req_pc;
    assign w_push_entry.instr = imem_rdata;

    // PC and in-flight request tracking; redirect overrides issue
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc     <= RESET_PC[PC_W-1:0];
            r_req_v  <= 1'b0;
            r_req_pc <= '0;
        end else if (PcSel) begin
            r_pc    <= w_redirect_pc;
            r_req_v <= 1'b0;
        end else begin
            r_req_v <= w_issue;
            if (w_issue) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + w_pc_inc;
            end
        end
    end

    fetch_skid_fifo u_skid_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_flush      (PcSel),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop & ~PcSel),
        .o_count      (w_count),
        .o_head       (w_head)
    );

    assign if_valid = (w_count != 2'd0);
    assign if_pc    = w_head.pc;
    assign if_instr = w_head.instr;

endmodule : fetch_pc_unit
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_pc_unit
//  Description : Self-checking bench for fetch_pc_unit. A transaction-level
//                model (PC counter, in-flight slot, queue of fetched PCs)
//                predicts every output each cycle; directed phases add
//                literal expectations, followed by randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_pc_unit;

    localparam int PC_W  = 9;
    localparam int INS_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic             PcSel;
    logic [31:0]      BrPC;
    logic             imem_en;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_rdata = '0;
    logic             if_valid;
    logic             id_ready;
    logic [PC_W-1:0]  if_pc;
    logic [INS_W-1:0] if_instr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.PC_W(PC_W), .INS_W(INS_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .PcSel      (PcSel),
        .BrPC       (BrPC),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .id_ready   (id_ready),
        .if_pc      (if_pc),
        .if_instr   (if_instr)
    );

    // Memory contents: each word encodes its own address
    function automatic logic [31:0] mem_word(input int addr);
        return 32'hA000_0000 | (addr & 32'h1FF);
    endfunction

    // Synchronous instruction memory
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(int'(imem_addr));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: next PC, one optional in-flight fetch, and the
    // ordered list of fetched PCs not yet accepted by decode.
    // ------------------------------------------------------------------
    int  m_pc     = 0;
    bit  m_infl   = 0;
    int  m_infl_pc = 0;
    int  mq[$];
    bit  m_init   = 0;

    function automatic bit model_issue();
        int outstanding;
        outstanding = mq.size() + (m_infl ? 1 : 0);
        if (mq.size() != 0 && id_ready) outstanding--;
        return (reset === 1'b1) && !PcSel && !stall && (outstanding < 2);
    endfunction

    always @(posedge clk) begin
        bit pop;
        bit iss;
        pop = (mq.size() != 0) && id_ready;
        iss = model_issue();
        if (reset !== 1'b1) begin
            mq.delete();
            m_infl = 0;
            m_pc   = 0;
            m_init = 1;
        end else if (PcSel) begin
            m_pc = int'(BrPC & 32'h1FC);
            mq.delete();
            m_infl = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_pc);
            m_infl = iss;
            if (iss) begin
                m_infl_pc = m_pc;
                m_pc = (m_pc + 4) % 512;
            end
        end
    end

    // Compare every output against the model, mid-cycle
    always @(negedge clk) begin
        bit  ev;
        int  epc;
        if (m_init) begin
            ev  = (mq.size() != 0);
            epc = ev ? mq[0] : 0;
            check("if_valid",  {31'b0, if_valid},  {31'b0, ev});
            check("if_pc",     {23'b0, if_pc},     epc);
            check("if_instr",  if_instr,           ev ? mem_word(epc) : 32'h0000_0013);
            check("imem_en",   {31'b0, imem_en},   {31'b0, model_issue()});
            check("imem_addr", {23'b0, imem_addr}, m_pc);
        end
    end

    // Apply one cycle of inputs just after the rising edge and return at
    // the following falling edge when outputs are settled
    task automatic step(input bit rs, input bit st, input bit ps, input bit rdy,
                        input logic [31:0] br);
        @(posedge clk);
        #1;
        reset    = rs;
        stall    = st;
        PcSel    = ps;
        id_ready = rdy;
        BrPC     = br;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; PcSel = 1'b0; id_ready = 1'b1; BrPC = '0;

        // Reset, then stream from 0 with decode always ready
        repeat (3) step(0, 0, 0, 1, 0);
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_instr", if_instr, 32'h0000_0013);
        check("rst_en",    {31'b0, imem_en}, 32'd0);
        step(1, 0, 0, 1, 0);
        check("s0_en",   {31'b0, imem_en}, 32'd1);
        check("s0_addr", {23'b0, imem_addr}, 32'h0);
        step(1, 0, 0, 1, 0);
        check("s1_addr",  {23'b0, imem_addr}, 32'h4);
        check("s1_valid", {31'b0, if_valid}, 32'd0);
        step(1, 0, 0, 1, 0);
        check("s2_valid", {31'b0, if_valid}, 32'd1);
        check("s2_pc",    {23'b0, if_pc}, 32'h0);
        check("s2_instr", if_instr, 32'hA000_0000);
        step(1, 0, 0, 1, 0);
        check("s3_pc",    {23'b0, if_pc}, 32'h4);
        check("s3_instr", if_instr, 32'hA000_0004);
        repeat (3) step(1, 0, 0, 1, 0);

        // Decode back-pressure for 5 cycles: fetch stops, head holds
        repeat (5) step(1, 0, 0, 0, 0);
        check("bp_en",    {31'b0, imem_en}, 32'd0);
        check("bp_pc",    {23'b0, if_pc}, 32'h14);
        check("bp_instr", if_instr, 32'hA000_0014);
        step(1, 0, 0, 1, 0);
        check("bp_rel0", {23'b0, if_pc}, 32'h14);
        step(1, 0, 0, 1, 0);
        check("bp_rel1", {23'b0, if_pc}, 32'h18);

        // Redirect with a full FIFO
        repeat (3) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 32'h0000_0123);
        step(1, 0, 0, 1, 0);
        check("rd1_valid", {31'b0, if_valid}, 32'd0);
        check("rd1_en",    {31'b0, imem_en}, 32'd1);
        check("rd1_addr",  {23'b0, imem_addr}, 32'h120);
        step(1, 0, 0, 1, 0);
        check("rd2_valid", {31'b0, if_valid}, 32'd0);
        step(1, 0, 0, 1, 0);
        check("rd3_valid", {31'b0, if_valid}, 32'd1);
        check("rd3_pc",    {23'b0, if_pc}, 32'h120);
        check("rd3_instr", if_instr, 32'hA000_0120);

        // Redirect during a 3-cycle stall
        step(1, 1, 1, 1, 32'h40);
        check("st0_en", {31'b0, imem_en}, 32'd0);
        step(1, 1, 0, 1, 0);
        check("st1_en", {31'b0, imem_en}, 32'd0);
        step(1, 1, 0, 1, 0);
        check("st2_en", {31'b0, imem_en}, 32'd0);
        step(1, 0, 0, 1, 0);
        check("st3_en",   {31'b0, imem_en}, 32'd1);
        check("st3_addr", {23'b0, imem_addr}, 32'h40);

        // PC wrap at the top of the address space
        step(1, 0, 1, 1, 32'h1F8);
        repeat (2) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        check("wr0_pc", {23'b0, if_pc}, 32'h1F8);
        step(1, 0, 0, 1, 0);
        check("wr1_pc", {23'b0, if_pc}, 32'h1FC);
        step(1, 0, 0, 1, 0);
        check("wr2_pc",    {23'b0, if_pc}, 32'h000);
        check("wr2_instr", if_instr, 32'hA000_0000);

        // One-cycle reset with a full FIFO
        repeat (4) step(1, 0, 0, 0, 0);
        check("mr_full", {31'b0, if_valid}, 32'd1);
        step(0, 0, 0, 0, 0);
        check("mr_en", {31'b0, imem_en}, 32'd0);
        step(1, 0, 0, 1, 0);
        check("mr_valid", {31'b0, if_valid}, 32'd0);
        check("mr_instr", if_instr, 32'h0000_0013);
        check("mr_addr",  {23'b0, imem_addr}, 32'h0);
        check("mr_en2",   {31'b0, imem_en}, 32'd1);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 99) < 7),
                 ($urandom_range(0, 9) < 7),
                 $urandom);
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fetch_pc_unit
`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage that owns the architectural PC and drives the synchronous instruction memory.
- Consumes the branch unit's redirect pair (PcSel, BrPC) and presents fetched (pc, instr) pairs to decode over a valid/ready handshake.
- Contains one in-flight request slot plus a 2-entry skid FIFO, so stalls and redirects never drop or duplicate instructions.

Parameters:
- PC_W, 9, PC/instruction-memory byte-address width.
- INS_W, 32, instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- stall  in  1  hazard-unit hold; no new fetch issued while 1.
- PcSel  in  1  redirect request (branch taken / jump) from branch unit.
- BrPC  in  32  redirect target, valid when PcSel=1.
- imem_en  out  1  instruction-memory read enable.
- imem_addr  out  PC_W  instruction-memory byte address.
- imem_rdata  in  INS_W  read data, valid the cycle after imem_en.
- if_valid  out  1  decode-side valid.
- id_ready  in  1  decode-side ready.
- if_pc  out  PC_W  PC of the presented instruction.
- if_instr  out  INS_W  presented instruction.

Behaviour:
- Reset (reset=0 at a clk edge):
  - pc_q=0, req_v_q=0, FIFO count=0.
  - if_valid=0, if_pc=0, if_instr=NOP_INSTR (32'h0000_0013), imem_en=0.
  - Reset mid-operation discards the in-flight request and all FIFO contents.
- Definitions:
  - pop = if_valid & id_ready.
  - occ = count + req_v_q.
  - issue = !PcSel & !stall & (occ - pop < 2).
- Memory interface: imem_en=issue; imem_addr=pc_q (combinational).
- On issue: req_v_q<=1, req_pc_q<=pc_q, pc_q<=pc_q+4 modulo 2^PC_W (0x1FC -> 0x000 for PC_W=9). Otherwise req_v_q<=0.
- Response: if req_v_q=1 and PcSel=0, {req_pc_q, imem_rdata} is written to the FIFO tail at the same edge.
- FIFO behaviour:
  - Simultaneous push and pop is legal at any count.
  - The credit rule guarantees no push when count=2 without a pop; an RTL assertion checks this.
- Output: if_valid=(count!=0); if_pc/if_instr come from the FIFO head. When empty, if_pc=0 and if_instr=NOP_INSTR.
- Decode handshake: the head is held stable while if_valid=1 and id_ready=0.
- Redirect (PcSel=1), which has priority over everything except reset:
  - pc_q<={BrPC[PC_W-1:2],2'b00}; upper bits are truncated and low bits forced to zero.
  - FIFO flushed (count<=0), in-flight response squashed (req_v_q<=0), no issue that cycle, any pop that cycle ignored.
  - Applies regardless of stall.
  - First fetch from the target issues the next cycle if stall=0.
- Latency and throughput:
  - Issue in cycle k gives if_valid in cycle k+2.
  - Redirect in cycle r gives the target on if_valid in cycle r+3.
  - Steady state is 1 instr/cycle with id_ready=1.
- stall=1 blocks new issues only. The in-flight response is still captured, and decode may keep draining the FIFO.

Decomposition:
- Package fetch_pkg: RESET_PC (0), NOP_INSTR (32'h0000_0013), PC_INC (4), FIFO_DEPTH (2), and the typedef fetch_entry_t {pc[PC_W-1:0], instr[INS_W-1:0]}.
- Sub-module fetch_skid_fifo: 2-entry FIFO of fetch_entry_t with push, pop, flush, count, and head output.
- PC register and credit logic stay in fetch_pc_unit.

Test Plan:
- Reset release with id_ready=1, imem returning addr|0xA000_0000:
  - imem_addr runs 0,4,8,… one per cycle.
  - if_valid first rises 2 cycles after the first imem_en.
  - if_pc sequence 0,4,8 with if_instr 0xA000_0000, 0xA000_0004, …
- id_ready=0 for 5 cycles mid-stream:
  - occ saturates at 2 and imem_en drops.
  - if_pc/if_instr hold.
  - After release the sequence continues with no gap or duplicate.
- PcSel=1, BrPC=0x0000_0123 while FIFO holds 2 entries and a request is in flight:
  - if_valid=0 the next cycle, then imem_addr=0x120.
  - if_pc=0x120 three cycles after the redirect; no stale entry is ever presented.
- stall=1 for 3 cycles concurrent with PcSel=1, BrPC=0x40:
  - No imem_en during the stall.
  - First issue after stall drops is addr 0x40.
- PC wrap: redirect to 0x1F8 → if_pc sequence 0x1F8, 0x1FC, 0x000.
- Assert reset=0 for one cycle mid-stream with FIFO full:
  - Next cycle if_valid=0, if_instr=0x0000_0013.
  - Fetch restarts at 0x000.
